// File: rtl/line_draw_engine_if.sv
// Command (valid/ready) and pixel-write (we/ready) channels of the line rasteriser.
interface line_draw_engine_if #(
    parameter int WIDTH_BITS = 6,
    parameter int COLOR_BITS = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [WIDTH_BITS-1:0]   cmd_x0;
    logic [WIDTH_BITS-1:0]   cmd_y0;
    logic [WIDTH_BITS-1:0]   cmd_x1;
    logic [WIDTH_BITS-1:0]   cmd_y1;
    logic [COLOR_BITS-1:0]   cmd_color;
    logic                    cmd_mode;
    logic                    pix_we;
    logic [2*WIDTH_BITS-1:0] pix_addr;
    logic [COLOR_BITS-1:0]   pix_data;
    logic                    pix_ready;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_mode, pix_ready,
        input  cmd_ready, pix_we, pix_addr, pix_data
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_mode, pix_ready,
        output cmd_ready, pix_we, pix_addr, pix_data
    );
endinterface

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: queued line commands in, one pixel write per cycle out,
// optional 2-on/2-off dashing, and a per-window count of completed lines.
module line_draw_engine #(
    parameter int WIDTH_BITS      = 6,
    parameter int COLOR_BITS      = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int COUNT_PERIOD    = 50000000
) (
    input  logic                     clk,
    input  logic                     reset,
    line_draw_engine_if.slave        bus,
    output logic                     busy,
    output logic [31:0]              count,
    output logic                     count_valid
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CMD_W = 4 * WIDTH_BITS + COLOR_BITS + 1;
    localparam int PER_W = $clog2(COUNT_PERIOD);

    typedef enum logic [1:0] {IDLE, LOAD, SETUP, DRAW} state_t;

    function automatic logic [WIDTH_BITS-1:0] abs_diff(input logic [WIDTH_BITS-1:0] a,
                                                       input logic [WIDTH_BITS-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [WIDTH_BITS-1:0] step_coord(input logic [WIDTH_BITS-1:0] v,
                                                         input logic up);
        return up ? (v + WIDTH_BITS'(1)) : (v - WIDTH_BITS'(1));
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic [CMD_W-1:0]           mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   occ, occ_next;
    logic                       push, pop, fifo_empty;

    state_t                       state;
    logic [WIDTH_BITS-1:0]        x0, y0, x1, y1, x, y;
    logic [COLOR_BITS-1:0]        color;
    logic                         mode;
    logic signed [WIDTH_BITS:0]   dx, dy;
    logic signed [WIDTH_BITS+1:0] err, err_next;
    logic signed [WIDTH_BITS+2:0] e2, dx_w, dy_w;
    logic                         sx_up, sy_up, move_x, move_y;
    logic [1:0]                   step, step_next;
    logic [WIDTH_BITS-1:0]        x_next, y_next, adx, ady;
    logic                         advance, at_end, line_done;

    logic [PER_W-1:0] period;
    logic [31:0]      lines_done;

    assign fifo_empty = (occ == '0);
    assign push       = bus.cmd_valid & bus.cmd_ready;
    assign advance    = (state == DRAW) && (!bus.pix_we || bus.pix_ready);
    assign at_end     = (x == x1) && (y == y1);
    assign line_done  = advance && at_end;
    // Finishing a line pops the next command directly so only LOAD and SETUP sit between lines.
    assign pop        = !fifo_empty && ((state == IDLE) || line_done);
    assign busy       = !fifo_empty || (state != IDLE);
    assign adx        = abs_diff(x0, x1);
    assign ady        = abs_diff(y0, y1);

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + (FIFO_DEPTH_BITS+1)'(1);
        else if (!push && pop)
            occ_next = occ - (FIFO_DEPTH_BITS+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            occ           <= occ_next;
            bus.cmd_ready <= (occ_next != (FIFO_DEPTH_BITS+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1, bus.cmd_color, bus.cmd_mode};
    end

    // Both error updates use the same e2 taken from the pre-step error.
    always_comb begin
        e2       = {err, 1'b0};
        dx_w     = {{2{dx[WIDTH_BITS]}}, dx};
        dy_w     = {{2{dy[WIDTH_BITS]}}, dy};
        move_x   = (e2 >= dy_w);
        move_y   = (e2 <= dx_w);
        err_next = err;
        if (move_x) err_next = err_next + {dy[WIDTH_BITS], dy};
        if (move_y) err_next = err_next + {dx[WIDTH_BITS], dx};
        x_next    = move_x ? step_coord(x, sx_up) : x;
        y_next    = move_y ? step_coord(y, sy_up) : y;
        step_next = step + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (pop)
            {x0, y0, x1, y1, color, mode} <= mem[rd_ptr];
        if (state == LOAD) begin
            dx    <= $signed({1'b0, adx});
            dy    <= -$signed({1'b0, ady});
            err   <= $signed({2'b00, adx}) - $signed({2'b00, ady});
            sx_up <= (x0 < x1);
            sy_up <= (y0 < y1);
            x     <= x0;
            y     <= y0;
            step  <= 2'd0;
        end else if (advance && !at_end) begin
            err  <= err_next;
            x    <= x_next;
            y    <= y_next;
            step <= step_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bus.pix_we   <= 1'b0;
            bus.pix_addr <= '0;
            bus.pix_data <= '0;
        end else begin
            case (state)
                IDLE:  if (!fifo_empty) state <= LOAD;
                LOAD:  state <= SETUP;
                SETUP: begin
                    state        <= DRAW;
                    bus.pix_we   <= !(mode && step[1]);
                    bus.pix_addr <= {y, x};
                    bus.pix_data <= color;
                end
                DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            bus.pix_we <= 1'b0;
                            state      <= fifo_empty ? IDLE : LOAD;
                        end else begin
                            bus.pix_we   <= !(mode && step_next[1]);
                            bus.pix_addr <= {y_next, x_next};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion on the wrap cycle still belongs to the window that is closing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            period      <= '0;
            lines_done  <= '0;
            count       <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (period == PER_W'(COUNT_PERIOD - 1)) begin
                period      <= '0;
                count       <= line_done ? sat_inc(lines_done) : lines_done;
                lines_done  <= '0;
                count_valid <= 1'b1;
            end else begin
                period <= period + PER_W'(1);
                if (line_done) lines_done <= sat_inc(lines_done);
            end
        end
    end
endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: directed scenarios plus random lines against a reference model.
module tb_line_draw_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [31:0] count;
    logic        count_valid;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int acc_edge;
    int rel_edge;
    int got_addr[$];
    int got_data[$];
    int got_edge[$];
    int exp_addr[$];
    int exp_data[$];
    int fx0[8], fy0[8], fx1[8], fy1[8], fcol[8];
    bit fmode[8];

    line_draw_engine_if #(.WIDTH_BITS(6), .COLOR_BITS(8)) bus ();

    line_draw_engine #(
        .WIDTH_BITS(6), .COLOR_BITS(8), .FIFO_DEPTH_BITS(2), .COUNT_PERIOD(100)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .busy(busy), .count(count), .count_valid(count_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && bus.pix_we && bus.pix_ready) begin
            got_addr.push_back(int'(bus.pix_addr));
            got_data.push_back(int'(bus.pix_data));
            got_edge.push_back(cyc + 1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic clear_q();
        got_addr.delete(); got_data.delete(); got_edge.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    // Reference: walk the line with integer Bresenham, dropping every 3rd/4th step when dashed.
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              input int color, input bit mode);
        int dx, dy, sx, sy, err, e2, x, y, i;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0; y = y0; i = 0;
        forever begin
            if (!mode || (i % 4) < 2) begin
                exp_addr.push_back(y * 64 + x);
                exp_data.push_back(color);
            end
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            i++;
        end
    endtask

    task automatic check_pixels(input string tag);
        check({tag, "_len"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int color, input bit mode);
        int n = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_x0 = 6'(x0); bus.cmd_y0 = 6'(y0);
        bus.cmd_x1 = 6'(x1); bus.cmd_y1 = 6'(y1);
        bus.cmd_color = 8'(color); bus.cmd_mode = mode;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            n++;
            if (n > 3000) begin timeout_fail("send_cmd"); break; end
        end
        @(posedge clk); #1;
        acc_edge = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_we(output int edge_no);
        edge_no = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (bus.pix_we) begin edge_no = cyc; break; end
        end
        if (edge_no < 0) timeout_fail("wait_we");
    endtask

    task automatic wait_idle(input bit rnd, output int fall);
        int n = 0;
        fall = -1;
        forever begin
            @(posedge clk); #1;
            if (!busy) begin fall = cyc; break; end
            if (rnd) bus.pix_ready = 1'($urandom_range(0, 1));
            n++;
            if (n > 5000) begin timeout_fail("wait_idle"); break; end
        end
        bus.pix_ready = 1'b1;
    endtask

    task automatic do_reset(input bit chk);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (chk) begin
            check("rst_pix_we", bus.pix_we, 0);
            check("rst_pix_addr", bus.pix_addr, 0);
            check("rst_pix_data", bus.pix_data, 0);
            check("rst_cmd_ready", bus.cmd_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_count", count, 0);
            check("rst_count_valid", count_valid, 0);
        end
        reset = 1'b1;
        rel_edge = cyc;
    endtask

    initial begin
        int f, fall, acc, sa, sd, t0;
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
        bus.cmd_color = '0; bus.cmd_mode = 1'b0;
        bus.pix_ready = 1'b1;

        do_reset(1'b1);

        // Solid horizontal: latency, throughput, busy fall
        clear_q();
        send_cmd(0, 0, 3, 0, 'h5A, 1'b0);
        wait_we(f);
        check("latency", f - acc_edge, 3);
        wait_idle(1'b0, fall);
        exp_addr = '{0, 1, 2, 3};
        exp_data = '{'h5A, 'h5A, 'h5A, 'h5A};
        check_pixels("solid");
        if (got_edge.size() == 4) begin
            check("solid_throughput", got_edge[3] - got_edge[0], 3);
            check("busy_fall", fall, got_edge[3]);
        end else timeout_fail("solid_edges");

        clear_q();
        send_cmd(5, 5, 2, 2, 'h11, 1'b0);
        wait_idle(1'b0, fall);
        exp_addr = '{325, 260, 195, 130};
        exp_data = '{'h11, 'h11, 'h11, 'h11};
        check_pixels("revdiag");

        clear_q();
        send_cmd(0, 0, 1, 3, 'h22, 1'b0);
        wait_idle(1'b0, fall);
        exp_addr = '{0, 64, 129, 193};
        exp_data = '{'h22, 'h22, 'h22, 'h22};
        check_pixels("steep");

        clear_q();
        send_cmd(7, 7, 7, 7, 'h33, 1'b0);
        wait_idle(1'b0, fall);
        exp_addr = '{455};
        exp_data = '{'h33};
        check_pixels("degen");

        clear_q();
        send_cmd(0, 0, 7, 0, 'h44, 1'b1);
        wait_we(f);
        wait_idle(1'b0, fall);
        exp_addr = '{0, 1, 4, 5};
        exp_data = '{'h44, 'h44, 'h44, 'h44};
        check_pixels("dashed");
        check("dashed_draw_cycles", fall - f, 8);

        // Back-to-back lines: two dead cycles between them
        clear_q();
        send_cmd(0, 20, 2, 20, 'h55, 1'b0);
        send_cmd(0, 21, 1, 21, 'h66, 1'b0);
        wait_idle(1'b0, fall);
        model_line(0, 20, 2, 20, 'h55, 1'b0);
        model_line(0, 21, 1, 21, 'h66, 1'b0);
        check_pixels("b2b");
        if (got_edge.size() == 5) begin
            check("b2b_rate", got_edge[1] - got_edge[0], 1);
            check("b2b_gap", got_edge[3] - got_edge[2], 3);
        end else timeout_fail("b2b_edges");

        // Backpressure hold
        clear_q();
        send_cmd(0, 10, 9, 13, 'h77, 1'b0);
        wait_we(f);
        repeat (2) @(posedge clk);
        #1;
        bus.pix_ready = 1'b0;
        sa = int'(bus.pix_addr);
        sd = int'(bus.pix_data);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_we", bus.pix_we, 1);
            check("hold_addr", bus.pix_addr, sa);
            check("hold_data", bus.pix_data, sd);
        end
        bus.pix_ready = 1'b1;
        wait_idle(1'b0, fall);
        model_line(0, 10, 9, 13, 'h77, 1'b0);
        check_pixels("bp");

        // Reset mid-line with commands still queued
        send_cmd(0, 30, 63, 30, 'h88, 1'b0);
        send_cmd(0, 31, 63, 31, 'h89, 1'b0);
        send_cmd(0, 32, 63, 32, 'h8A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_pix_we", bus.pix_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        reset = 1'b1;
        clear_q();
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_pixels", got_addr.size(), 0);
        check("midrst_idle", busy, 0);

        // FIFO full under backpressure, then drain in order
        clear_q();
        for (int i = 0; i < 8; i++) begin
            fx0[i] = $urandom_range(0, 63); fy0[i] = $urandom_range(0, 63);
            fx1[i] = $urandom_range(0, 63); fy1[i] = $urandom_range(0, 63);
            fcol[i] = $urandom_range(0, 255); fmode[i] = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        bus.pix_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (acc < 8) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_x0 = 6'(fx0[acc]); bus.cmd_y0 = 6'(fy0[acc]);
                bus.cmd_x1 = 6'(fx1[acc]); bus.cmd_y1 = 6'(fy1[acc]);
                bus.cmd_color = 8'(fcol[acc]); bus.cmd_mode = fmode[acc];
            end else bus.cmd_valid = 1'b0;
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) acc++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("full_accepted", acc, 5);
        check("full_cmd_ready", bus.cmd_ready, 0);
        for (int i = 0; i < 5; i++) model_line(fx0[i], fy0[i], fx1[i], fy1[i], fcol[i], fmode[i]);
        bus.pix_ready = 1'b1;
        wait_idle(1'b0, fall);
        check_pixels("full_drain");

        // Random lines with random backpressure
        for (int b = 0; b < 10; b++) begin
            clear_q();
            for (int i = 0; i < 3; i++) begin
                fx0[i] = $urandom_range(0, 63); fy0[i] = $urandom_range(0, 63);
                fx1[i] = $urandom_range(0, 63); fy1[i] = $urandom_range(0, 63);
                fcol[i] = $urandom_range(0, 255); fmode[i] = 1'($urandom_range(0, 1));
                model_line(fx0[i], fy0[i], fx1[i], fy1[i], fcol[i], fmode[i]);
                send_cmd(fx0[i], fy0[i], fx1[i], fy1[i], fcol[i], fmode[i]);
            end
            wait_idle(1'b1, fall);
            check_pixels($sformatf("rand%0d", b));
        end

        // Rate counter over two windows
        do_reset(1'b0);
        send_cmd(1, 1, 2, 1, 'h01, 1'b0);
        send_cmd(3, 3, 3, 3, 'h02, 1'b0);
        send_cmd(4, 4, 5, 5, 'h03, 1'b1);
        wait_idle(1'b0, fall);
        t0 = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (count_valid) begin t0 = cyc; break; end
        end
        if (t0 < 0) timeout_fail("count_valid1");
        else begin
            check("window1_edge", t0 - rel_edge, 100);
            check("window1_count", count, 3);
            f = -1;
            for (int n = 0; n < 300; n++) begin
                @(posedge clk); #1;
                if (count_valid) begin f = cyc; break; end
            end
            if (f < 0) timeout_fail("count_valid2");
            else begin
                check("window2_period", f - t0, 100);
                check("window2_count", count, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_draw_engine.md
Name: line_draw_engine

Overview:
- Parametrised Bresenham line rasteriser for the line benchmark path.
- Accepts line commands through a queued valid/ready port and emits one pixel write per cycle toward the framebuffer write port, with backpressure.
- Adds a dashed drawing mode.
- Reports completed lines per measurement period.

Parameters:
WIDTH_BITS, 6, bits per coordinate axis; screen is 2^WIDTH_BITS x 2^WIDTH_BITS
COLOR_BITS, 8, pixel colour width
FIFO_DEPTH_BITS, 2, command FIFO depth = 2^FIFO_DEPTH_BITS entries
COUNT_PERIOD, 50000000, measurement window length in clk cycles (>=2)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous active-low reset (0 = reset)
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !fifo_full, registered
cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  WIDTH_BITS each  start and end point, unsigned
cmd_color  in  COLOR_BITS  line colour
cmd_mode  in  1  0 = solid, 1 = dashed
pix_we  out  1  pixel write valid
pix_addr  out  2*WIDTH_BITS  {y, x}
pix_data  out  COLOR_BITS  colour
pix_ready  in  1  sink accepts pixel; transfer = pix_we & pix_ready
busy  out  1  FIFO non-empty or FSM != IDLE
count  out  32  lines completed in the last full window
count_valid  out  1  one-cycle pulse when count updates

Behaviour:
- Reset (reset==0 at a clk edge), including mid-line:
  - FIFO emptied; FSM to IDLE.
  - pix_we=0, pix_addr=0, pix_data=0; cmd_ready=1; busy=0; count=0; count_valid=0.
  - Period and line counters cleared.
  - An in-flight line is abandoned; none of its remaining pixels is emitted.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready is registered and reflects occupancy after the current edge; a pop in the same cycle does not raise it until the next cycle.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged.
- FSM IDLE -> LOAD -> SETUP -> DRAW -> IDLE.
- IDLE: if FIFO non-empty, pop into working registers, go to LOAD.
- LOAD -> SETUP:
  - dx = |x1-x0| and dy = -|y1-y0|, both signed WIDTH_BITS+1.
  - sx = (x0<x1) ? +1 : -1; sy = (y0<y1) ? +1 : -1.
  - err = dx+dy, signed WIDTH_BITS+2.
  - x = x0, y = y0, step = 0.
- SETUP -> DRAW: pix_we = !(mode & step[1]); pix_addr = {y, x}; pix_data = color.
- DRAW advances on (pix_we & pix_ready), or unconditionally when pix_we=0 (dash gap).
  - On advance, if x==x1 and y==y1: line done; go to IDLE, or LOAD if FIFO non-empty.
  - Otherwise:
    - e2 = 2*err.
    - if e2>=dy: err += dy, x += sx.
    - if e2<=dx: err += dx, y += sy; both err updates apply when both conditions hold.
    - step += 1; output the next pixel with pix_we recomputed.
  - Without advance: pix_we, pix_addr and pix_data are held stable.
- Pixels per line = max(|dx|,|dy|)+1, endpoints inclusive. A degenerate line emits one pixel.
- Dashed mode: pattern 2 on / 2 off from the start point; off pixels cost one cycle each with pix_we=0.
- Latency: a command accepted at edge E into an empty, idle engine has its first pix_we high after edge E+3.
  - Throughput: 1 pixel/clk with pix_ready held high.
  - Back-to-back lines: 2 dead cycles between the last pixel of one line and the first pixel of the next.
- Rate counter:
  - Period counter runs 0..COUNT_PERIOD-1, then wraps.
  - lines_done increments on each line completion.
  - On wrap, count <= lines_done, including a completion in the same cycle; lines_done restarts at 0; count_valid pulses 1 cycle.
  - lines_done saturates at 2^32-1.

Test Plan:
- Solid (0,0)->(3,0), colour 0x5A, pix_ready=1 -> pix_addr 0,1,2,3 on consecutive cycles, pix_data 0x5A; first pix_we 3 cycles after accept; busy falls the cycle after the last write.
- Reverse diagonal (5,5)->(2,2) -> addrs 325,260,195,130; steep (0,0)->(1,3) -> addrs 0,64,129,193.
- Degenerate (7,7)->(7,7) -> exactly one write, addr 455; dashed (0,0)->(7,0) mode=1 -> writes only at addrs 0,1,4,5, and 8 cycles spent in DRAW.
- Backpressure: pix_ready=0 for 3 cycles mid-line -> pix_we, pix_addr and pix_data held constant; no pixel skipped or duplicated. Reset asserted mid-line -> pix_we=0 next cycle; FIFO empty; busy=0.
- FIFO full: pix_ready=0, offer 8 commands -> 5 accepted (1 in engine, 4 in FIFO), then cmd_ready=0; releasing pix_ready drains all 5 lines in order.
- COUNT_PERIOD=100, 3 short lines drawn inside the window -> count_valid pulses at cycle 100 with count=3; next window with no lines -> count=0.
